// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - prioritised exception sequencer: flush, redirect, handler, return
// Optional nested exceptions with an EPC/cause stack are enabled by defining EXC_NEST_EN.
module exception_ctrl #(
  parameter int unsigned     NUM_CAUSES   = 4,
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] HANDLER_ADDR = 32'h8000_0180,
  parameter int unsigned     NEST_DEPTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CAUSES-1:0]         exc_req,
  input  logic [NUM_CAUSES*XLEN-1:0]    exc_pc,
  input  logic                          eret,
  input  logic                          mask_we,
  input  logic [NUM_CAUSES-1:0]         mask_wdata,
  output logic                          if_flush,
  output logic                          id_flush,
  output logic                          ex_flush,
  output logic                          pc_sel,
  output logic [XLEN-1:0]               redirect_pc,
  output logic [XLEN-1:0]               epc,
  output logic [$clog2(NUM_CAUSES)-1:0] cause,
  output logic                          exc_active,
  output logic                          lost_exc
);

  localparam int CW = $clog2(NUM_CAUSES);

  if (NUM_CAUSES < 2 || NUM_CAUSES > 16 || NEST_DEPTH < 1) begin : g_param_check
    $error("exception_ctrl: NUM_CAUSES must be 2..16 and NEST_DEPTH at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_REDIRECT,
    S_HANDLER,
    S_RETURN
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [NUM_CAUSES-1:0]   r_mask;
  logic [XLEN-1:0]         r_epc;
  logic [CW-1:0]           r_cause;
  logic                    r_lost;

  logic [NUM_CAUSES-1:0]   w_pending;
  logic [CW-1:0]           w_win;
  logic [XLEN-1:0]         w_win_pc;
  logic                    w_take;
  logic                    w_drop;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_can_push;
  logic                    w_stk_nonempty;
  logic [XLEN-1:0]         w_pop_epc;
  logic [CW-1:0]           w_pop_cause;

  assign w_pending = exc_req & r_mask;

  // Scan from the lowest priority upward so the lowest set index is left standing.
  always_comb begin
    w_win    = '0;
    w_win_pc = '0;
    for (int i = int'(NUM_CAUSES) - 1; i >= 0; i--) begin
      if (w_pending[i]) begin
        w_win    = CW'(i);
        w_win_pc = exc_pc[i*XLEN +: XLEN];
      end
    end
  end

`ifdef EXC_NEST_EN
  localparam int SPW = $clog2(NEST_DEPTH + 1);
  localparam int IW  = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

  logic [SPW-1:0]  r_sp;
  logic [XLEN-1:0] r_stk_epc   [NEST_DEPTH];
  logic [CW-1:0]   r_stk_cause [NEST_DEPTH];
  logic [IW-1:0]   w_push_idx;
  logic [IW-1:0]   w_pop_idx;

  assign w_can_push     = (r_sp < SPW'(NEST_DEPTH));
  assign w_stk_nonempty = (r_sp != '0);
  assign w_push_idx     = IW'(r_sp);
  assign w_pop_idx      = IW'(r_sp - 1'b1);
  assign w_pop_epc      = r_stk_epc[w_pop_idx];
  assign w_pop_cause    = r_stk_cause[w_pop_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp <= '0;
    end else if (w_push) begin
      r_stk_epc[w_push_idx]   <= r_epc;
      r_stk_cause[w_push_idx] <= r_cause;
      r_sp                    <= r_sp + 1'b1;
    end else if (w_pop) begin
      r_sp <= r_sp - 1'b1;
    end
  end
`else
  assign w_can_push     = 1'b0;
  assign w_stk_nonempty = 1'b0;
  assign w_pop_epc      = '0;
  assign w_pop_cause    = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_take      = 1'b0;
    w_drop      = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    if_flush    = 1'b0;
    id_flush    = 1'b0;
    ex_flush    = 1'b0;
    pc_sel      = 1'b0;
    redirect_pc = '0;
    exc_active  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (|w_pending) begin
          w_take = 1'b1;
          w_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_next = S_REDIRECT;
      end
      S_REDIRECT: begin
        w_next = S_HANDLER;
      end
      S_HANDLER: begin
        if ((|w_pending) && w_can_push) begin
          w_take = 1'b1;
          w_push = 1'b1;
          w_next = S_FLUSH;
        end else begin
          w_drop = |w_pending;
          if (eret) begin
            w_next = S_RETURN;
          end
        end
      end
      S_RETURN: begin
        if (w_stk_nonempty) begin
          w_pop  = 1'b1;
          w_next = S_HANDLER;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase

    // Pipeline-facing outputs are forced quiet while reset is held.
    if (!rst) begin
      exc_active = (r_state != S_IDLE);
      case (r_state)
        S_FLUSH: begin
          if_flush = 1'b1;
          id_flush = 1'b1;
          ex_flush = 1'b1;
        end
        S_REDIRECT: begin
          pc_sel      = 1'b1;
          redirect_pc = HANDLER_ADDR;
        end
        S_RETURN: begin
          pc_sel      = 1'b1;
          redirect_pc = r_epc;
          if_flush    = 1'b1;
          id_flush    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask  <= '1;
      r_epc   <= '0;
      r_cause <= '0;
      r_lost  <= 1'b0;
    end else begin
      if (mask_we) begin
        r_mask <= mask_wdata;
      end
      if (w_drop) begin
        r_lost <= 1'b1;
      end
      if (w_take) begin
        r_epc   <= w_win_pc;
        r_cause <= w_win;
      end else if (w_pop) begin
        r_epc   <= w_pop_epc;
        r_cause <= w_pop_cause;
      end
    end
  end

  assign epc      = r_epc;
  assign cause    = r_cause;
  assign lost_exc = r_lost;

endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - self-checking bench for exception_ctrl
// Table vectors, hand-written sequences and a randomized run against a queue-based model.
module tb_exception_ctrl;

  localparam int NC = 4;
  localparam int XL = 32;
  localparam int ND = 2;
  localparam logic [31:0] HADDR = 32'h8000_0180;
`ifdef EXC_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [NC-1:0]   exc_req;
  logic [NC*XL-1:0] exc_pc;
  logic            eret;
  logic            mask_we;
  logic [NC-1:0]   mask_wdata;
  logic            if_flush, id_flush, ex_flush, pc_sel, exc_active, lost_exc;
  logic [XL-1:0]   redirect_pc, epc;
  logic [1:0]      cause;

  exception_ctrl #(
    .NUM_CAUSES  (NC),
    .XLEN        (XL),
    .HANDLER_ADDR(HADDR),
    .NEST_DEPTH  (ND)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .exc_req    (exc_req),
    .exc_pc     (exc_pc),
    .eret       (eret),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .if_flush   (if_flush),
    .id_flush   (id_flush),
    .ex_flush   (ex_flush),
    .pc_sel     (pc_sel),
    .redirect_pc(redirect_pc),
    .epc        (epc),
    .cause      (cause),
    .exc_active (exc_active),
    .lost_exc   (lost_exc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flag order: {if_flush, id_flush, ex_flush, pc_sel, exc_active, lost_exc}
  function automatic logic [5:0] flags();
    return {if_flush, id_flush, ex_flush, pc_sel, exc_active, lost_exc};
  endfunction

  task automatic drive(input logic [3:0] req, input logic er, input logic mwe, input logic [3:0] mwd);
    exc_req = req; eret = er; mask_we = mwe; mask_wdata = mwd;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'h0, 1'b0, 1'b0, 4'h0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_pc(input int i, input logic [31:0] v);
    exc_pc[i*XL +: XL] = v;
  endtask

  // ---------------- reference model ----------------
  typedef enum int {K_IDLE, K_FLUSH, K_REDIR, K_HANDLER, K_RETURN} kind_e;
  kind_e        m_kind;
  kind_e        sched[$];
  logic [33:0]  stk[$];
  bit           m_in, m_ret, m_lost;
  logic [3:0]   m_mask;
  logic [31:0]  m_epc, m_rpc;
  logic [1:0]   m_cause;

  task automatic model_reset();
    m_kind = K_IDLE; sched.delete(); stk.delete();
    m_in = 0; m_ret = 0; m_lost = 0; m_mask = 4'hF;
    m_epc = 0; m_rpc = 0; m_cause = 0;
  endtask

  task automatic model_edge();
    logic [3:0] pend;
    int w;
    pend = exc_req & m_mask;
    if (mask_we) m_mask = mask_wdata;
    if (m_ret) begin
      m_ret = 0;
      if (stk.size() > 0) begin
        {m_epc, m_cause} = stk.pop_back();
        m_kind = K_HANDLER;
      end else begin
        m_in = 0;
        m_kind = K_IDLE;
      end
    end else if (sched.size() > 0) begin
      m_kind = sched.pop_front();
    end else if (pend != 0 && (!m_in || (NEST && stk.size() < ND))) begin
      if (m_in) stk.push_back({m_epc, m_cause});
      w = 0;
      for (int i = NC - 1; i >= 0; i--) if (pend[i]) w = i;
      m_epc = exc_pc[w*XL +: XL];
      m_cause = 2'(w);
      m_in = 1;
      m_kind = K_FLUSH;
      sched.push_back(K_REDIR);
      sched.push_back(K_HANDLER);
    end else if (m_in) begin
      if (pend != 0) m_lost = 1;
      if (eret) begin
        m_kind = K_RETURN; m_rpc = m_epc; m_ret = 1;
      end else begin
        m_kind = K_HANDLER;
      end
    end else begin
      m_kind = K_IDLE;
    end
  endtask

  function automatic logic [127:0] model_out();
    logic [5:0]  f;
    logic [31:0] r;
    f = 6'b0; r = 32'h0;
    case (m_kind)
      K_FLUSH:   f = 6'b111010;
      K_REDIR:   begin f = 6'b000110; r = HADDR; end
      K_HANDLER: f = 6'b000010;
      K_RETURN:  begin f = 6'b110110; r = m_rpc; end
      default:   f = 6'b0;
    endcase
    f[0] = m_lost;
    return {f, r, m_epc, m_cause};
  endfunction

  // ---------------- table vectors ----------------
  typedef struct {
    logic [3:0]  mask;
    logic [3:0]  req;
    logic        take;
    logic [1:0]  cause;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exc_pc = '0;
    set_pc(0, 32'h0000_0014);
    set_pc(1, 32'h2000_0040);
    set_pc(2, 32'h3000_0080);
    set_pc(3, 32'h4000_00C0);
    drive(4'h0, 1'b0, 1'b0, 4'h0);

    vecs[0] = '{4'hF, 4'b0001, 1'b1, 2'd0, 32'h0000_0014};
    vecs[1] = '{4'hF, 4'b0110, 1'b1, 2'd1, 32'h2000_0040};
    vecs[2] = '{4'hE, 4'b0001, 1'b0, 2'd0, 32'h0000_0000};
    vecs[3] = '{4'hE, 4'b0011, 1'b1, 2'd1, 32'h2000_0040};
    vecs[4] = '{4'hF, 4'b1000, 1'b1, 2'd3, 32'h4000_00C0};
    vecs[5] = '{4'h0, 4'b1111, 1'b0, 2'd0, 32'h0000_0000};
    vecs[6] = '{4'hA, 4'b1111, 1'b1, 2'd1, 32'h2000_0040};
    vecs[7] = '{4'h8, 4'b1100, 1'b1, 2'd3, 32'h4000_00C0};

    // Reset state
    do_reset();
    chk("reset_flags", flags(), 6'b0);
    chk("reset_epc", epc, 0);
    chk("reset_cause", cause, 0);
    chk("reset_rpc", redirect_pc, 0);

    foreach (vecs[v]) begin
      do_reset();
      if (vecs[v].mask != 4'hF) begin
        drive(4'h0, 1'b0, 1'b1, vecs[v].mask);
        tick();
      end
      drive(vecs[v].req, 1'b0, 1'b0, 4'h0);
      tick();
      chk($sformatf("vec%0d_take", v), ex_flush, vecs[v].take);
      chk($sformatf("vec%0d_cause", v), cause, vecs[v].cause);
      chk($sformatf("vec%0d_epc", v), epc, vecs[v].epc);
    end

    // Full sequence; requests during FLUSH/REDIRECT are ignored and not lost
    do_reset();
    drive(4'b0001, 1'b0, 1'b0, 4'h0);
    tick();
    chk("seq_flush", flags(), 6'b111010);
    chk("seq_flush_rpc", redirect_pc, 0);
    drive(4'b0010, 1'b0, 1'b0, 4'h0);
    tick();
    chk("seq_redir", flags(), 6'b000110);
    chk("seq_redir_rpc", redirect_pc, HADDR);
    tick();
    chk("seq_handler", flags(), 6'b000010);
    chk("seq_handler_cause", cause, 0);
    chk("seq_handler_rpc", redirect_pc, 0);

`ifdef EXC_NEST_EN
    drive(4'b0010, 1'b0, 1'b0, 4'h0); set_pc(1, 32'hE2E2_0000); tick();
    drive(4'b0000, 1'b0, 1'b0, 4'h0); tick(); tick();
    chk("nest1_epc", epc, 32'hE2E2_0000);
    chk("nest1_flags", flags(), 6'b000010);
    drive(4'b0100, 1'b0, 1'b0, 4'h0); set_pc(2, 32'hE3E3_0000); tick();
    drive(4'b0000, 1'b0, 1'b0, 4'h0); tick(); tick();
    chk("nest2_epc", epc, 32'hE3E3_0000);
    drive(4'b1000, 1'b0, 1'b0, 4'h0); tick();
    chk("nest3_lost", flags(), 6'b000011);
    chk("nest3_epc", epc, 32'hE3E3_0000);
    drive(4'b0000, 1'b1, 1'b0, 4'h0); tick();
    chk("nret1_rpc", redirect_pc, 32'hE3E3_0000);
    drive(4'b0000, 1'b0, 1'b0, 4'h0); tick();
    chk("nret1_epc", epc, 32'hE2E2_0000);
    drive(4'b0000, 1'b1, 1'b0, 4'h0); tick();
    chk("nret2_rpc", redirect_pc, 32'hE2E2_0000);
    drive(4'b0000, 1'b0, 1'b0, 4'h0); tick();
    chk("nret2_epc", epc, 32'h0000_0014);
    chk("nret2_cause", cause, 0);
    chk("nret2_flags", flags(), 6'b000011);
`else
    drive(4'b0100, 1'b0, 1'b0, 4'h0);
    tick();
    chk("drop_flags", flags(), 6'b000011);
    chk("drop_epc", epc, 32'h0000_0014);
    chk("drop_cause", cause, 0);
`endif
    drive(4'b0000, 1'b1, 1'b0, 4'h0);
    tick();
    chk("ret_flags", flags() & 6'b111110, 6'b110110);
    chk("ret_rpc", redirect_pc, 32'h0000_0014);
    drive(4'b0000, 1'b0, 1'b0, 4'h0);
    tick();
    chk("ret_idle", flags() & 6'b111110, 6'b0);
    chk("ret_idle_rpc", redirect_pc, 0);

    // Exception beats eret in IDLE; mask write applies only from the next cycle
    do_reset();
    drive(4'b0100, 1'b1, 1'b1, 4'h0);
    tick();
    chk("eret_race_flags", flags(), 6'b111010);
    chk("eret_race_cause", cause, 2);
    drive(4'b0000, 1'b0, 1'b0, 4'h0);
    tick(); tick();
    drive(4'b0000, 1'b1, 1'b0, 4'h0); tick();
    drive(4'b0000, 1'b0, 1'b0, 4'h0); tick();
    drive(4'b1111, 1'b0, 1'b0, 4'h0); tick();
    chk("mask_zero_idle", flags(), 6'b0);

    // Reset asserted in REDIRECT
    do_reset();
    drive(4'b0001, 1'b0, 1'b0, 4'h0); tick();
    drive(4'b0000, 1'b0, 1'b0, 4'h0); tick();
    chk("rst_mid_redir", pc_sel, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_hold_flags", flags(), 6'b0);
    tick();
    chk("rst_after_flags", flags(), 6'b0);
    chk("rst_after_epc", epc, 0);
    rst = 1'b0;
    tick();
    chk("rst_no_resume", flags(), 6'b0);

    // Randomized run against the model
    do_reset();
    model_reset();
    for (int c = 0; c < 800; c++) begin
      logic [3:0] rq, md;
      rq = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      md = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      drive(rq, ($urandom_range(0, 3) == 0), ($urandom_range(0, 24) == 0), md);
      for (int i = 0; i < NC; i++) set_pc(i, $urandom);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk($sformatf("rand%0d", c), {flags(), redirect_pc, epc, cause}, model_out());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
